// File: rtl/data_mem_bytelane_if.sv
// Request/response bus between the MEM stage or multicycle control and data_mem_bytelane.
interface data_mem_bytelane_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_bytelane.sv
// Byte-lane data memory with request/response handshake, programmable wait states,
// sign/zero-extending loads and error flagging for misaligned/out-of-range/illegal accesses.
module data_mem_bytelane #(
  parameter int    DEPTH       = 256,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input logic                clk,
  input logic                rst_n,
  data_mem_bytelane_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        lat_we, lat_uns;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr, lat_wdata;

  logic [31:0] mem [DEPTH];

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // With zero wait states the commit edge is the accept edge, so the live
  // request is used in IDLE and the latched copy everywhere else.
  logic        c_we, c_uns, c_err, commit;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata;
  logic [AW-1:0] idx;
  logic [31:0] old_word, new_word, load_val, wd;
  logic [3:0]  be;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    if (state == IDLE) begin
      c_we    = bus.req_we;
      c_uns   = bus.req_unsigned;
      c_size  = bus.req_size;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
    end else begin
      c_we    = lat_we;
      c_uns   = lat_uns;
      c_size  = lat_size;
      c_addr  = lat_addr;
      c_wdata = lat_wdata;
    end
  end

  always_comb begin
    c_err = 1'b0;
    case (c_size)
      2'b01:   c_err = c_addr[0];
      2'b10:   c_err = |c_addr[1:0];
      2'b11:   c_err = 1'b1;
      default: c_err = 1'b0;
    endcase
    if (c_addr[31:2] >= 30'(DEPTH)) c_err = 1'b1;
  end

  assign idx      = c_addr[AW+1:2];
  assign old_word = mem[idx];
  assign sel_byte = old_word[{c_addr[1:0], 3'b000} +: 8];
  assign sel_half = old_word[{c_addr[1], 4'b0000} +: 16];
  assign commit   = (state != RESP) && (state_nxt == RESP);

  always_comb begin
    be       = '0;
    wd       = c_wdata;
    load_val = old_word;
    case (c_size)
      2'b00: begin
        be       = 4'b0001 << c_addr[1:0];
        wd       = {4{c_wdata[7:0]}};
        load_val = {{24{~c_uns & sel_byte[7]}}, sel_byte};
      end
      2'b01: begin
        be       = c_addr[1] ? 4'b1100 : 4'b0011;
        wd       = {2{c_wdata[15:0]}};
        load_val = {{16{~c_uns & sel_half[15]}}, sel_half};
      end
      default: begin
        be       = 4'b1111;
        wd       = c_wdata;
        load_val = old_word;
      end
    endcase
    new_word = old_word;
    for (int unsigned k = 0; k < 4; k++)
      if (be[k]) new_word[8*k +: 8] = wd[8*k +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      lat_we         <= 1'b0;
      lat_uns        <= 1'b0;
      lat_size       <= '0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        lat_we    <= bus.req_we;
        lat_uns   <= bus.req_unsigned;
        lat_size  <= bus.req_size;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        cnt       <= CNT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        bus.resp_err   <= c_err;
        bus.resp_rdata <= (c_err || c_we) ? '0 : load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && c_we && !c_err) mem[idx] <= new_word;
  end

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Bench for data_mem_bytelane: three instances (1, 0 and 3 wait states) sharing one driver.
module tb_data_mem_bytelane;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b1;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;

  logic        rdy_a [3], val_a [3], err_a [3];
  logic [31:0] dat_a [3];
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    data_mem_bytelane_if bus ();
    assign bus.req_valid    = req_valid && (sel == g);
    assign bus.req_we       = req_we;
    assign bus.req_size     = req_size;
    assign bus.req_unsigned = req_unsigned;
    assign bus.req_addr     = req_addr;
    assign bus.req_wdata    = req_wdata;
    assign bus.resp_ready   = (sel == g) ? resp_ready : 1'b1;
    assign rdy_a[g] = bus.req_ready;
    assign val_a[g] = bus.resp_valid;
    assign err_a[g] = bus.resp_err;
    assign dat_a[g] = bus.resp_rdata;
    data_mem_bytelane #(.DEPTH(256), .WAIT_STATES(WS), .INIT_FILE("")) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  assign req_ready  = rdy_a[sel];
  assign resp_valid = val_a[sel];
  assign resp_err   = err_a[sel];
  assign resp_rdata = dat_a[sel];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq [$];
  vec_t vt  [$];
  int   total = 0;
  int   bad   = 0;

  function automatic int ws_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 0 : 3;
  endfunction

  function automatic vec_t v(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input logic err);
    vec_t r;
    r.we = we; r.size = size; r.uns = uns; r.addr = addr;
    r.wdata = wdata; r.rdata = rdata; r.err = err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_req(input vec_t t, input int hold, input string nm);
    int   n;
    exp_t e;
    wait_ready(nm);
    sbq.push_back('{t.rdata, t.err});
    drive(t.we, t.size, t.uns, t.addr, t.wdata);
    resp_ready = (hold == 0);
    n = 1;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({nm, " latency"}, 32'(n), 32'(ws_of(sel) + 1));
    e = sbq.pop_front();
    chk({nm, " rdata"}, resp_rdata, e.rdata);
    chk({nm, " err"}, 32'(resp_err), 32'(e.err));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({nm, " hold valid"}, 32'(resp_valid), 32'd1);
        chk({nm, " hold rdata"}, resp_rdata, e.rdata);
        chk({nm, " hold req_ready"}, 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      chk({nm, " release valid"}, 32'(resp_valid), 32'd0);
      chk({nm, " release req_ready"}, 32'(req_ready), 32'd1);
    end
  endtask

  // Holds a transaction in RESP, then resets: the response must vanish at once.
  task automatic rst_in_resp(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input string nm);
    int n = 0;
    wait_ready(nm);
    resp_ready = 1'b0;
    drive(we, 2'b10, 1'b0, addr, wdata);
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({nm, " valid before reset"}, 32'(resp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk({nm, " valid in reset"}, 32'(resp_valid), 32'd0);
    chk({nm, " rdata in reset"}, resp_rdata, 32'd0);
    chk({nm, " req_ready in reset"}, 32'(req_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    vt.push_back(v(1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0));
    vt.push_back(v(0, 2'd2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0));
    vt.push_back(v(1, 2'd0, 0, 32'h11,  32'h12345680, 32'h0,        0));
    vt.push_back(v(0, 2'd2, 0, 32'h10,  32'h0,        32'hDEAD80EF, 0));
    vt.push_back(v(0, 2'd0, 0, 32'h11,  32'h0,        32'hFFFFFF80, 0));
    vt.push_back(v(0, 2'd0, 1, 32'h11,  32'h0,        32'h00000080, 0));
    vt.push_back(v(0, 2'd0, 0, 32'h10,  32'h0,        32'hFFFFFFEF, 0));
    vt.push_back(v(0, 2'd0, 1, 32'h12,  32'h0,        32'h000000AD, 0));
    vt.push_back(v(0, 2'd0, 0, 32'h13,  32'h0,        32'hFFFFFFDE, 0));
    vt.push_back(v(1, 2'd1, 0, 32'h22,  32'hABCD1234, 32'h0,        0));
    vt.push_back(v(0, 2'd2, 0, 32'h20,  32'h0,        32'h12340000, 0));
    vt.push_back(v(0, 2'd1, 0, 32'h22,  32'h0,        32'h00001234, 0));
    vt.push_back(v(1, 2'd1, 0, 32'h22,  32'hFFFF8001, 32'h0,        0));
    vt.push_back(v(0, 2'd1, 0, 32'h22,  32'h0,        32'hFFFF8001, 0));
    vt.push_back(v(0, 2'd1, 1, 32'h22,  32'h0,        32'h00008001, 0));
    vt.push_back(v(0, 2'd1, 0, 32'h20,  32'h0,        32'h00000000, 0));
    vt.push_back(v(0, 2'd2, 0, 32'h13,  32'h0,        32'h0,        1));
    vt.push_back(v(1, 2'd1, 0, 32'h21,  32'hFFFFFFFF, 32'h0,        1));
    vt.push_back(v(1, 2'd2, 0, 32'h400, 32'h11111111, 32'h0,        1));
    vt.push_back(v(1, 2'd2, 0, 32'hFFFFFFFC, 32'h22222222, 32'h0,   1));
    vt.push_back(v(1, 2'd3, 0, 32'h10,  32'h0,        32'h0,        1));
    vt.push_back(v(0, 2'd3, 0, 32'h10,  32'h0,        32'h0,        1));
    vt.push_back(v(0, 2'd2, 0, 32'h10,  32'h0,        32'hDEAD80EF, 0));
    vt.push_back(v(0, 2'd2, 0, 32'h20,  32'h0,        32'h80010000, 0));
    vt.push_back(v(0, 2'd2, 0, 32'h0,   32'h0,        32'h00000000, 0));
    vt.push_back(v(1, 2'd2, 0, 32'h3FC, 32'hCAFEF00D, 32'h0,        0));
    vt.push_back(v(0, 2'd2, 0, 32'h3FC, 32'h0,        32'hCAFEF00D, 0));
    vt.push_back(v(1, 2'd0, 0, 32'h13,  32'h1234567F, 32'h0,        0));
    vt.push_back(v(0, 2'd2, 1, 32'h10,  32'h0,        32'h7FAD80EF, 0));
    vt.push_back(v(0, 2'd1, 0, 32'h12,  32'h0,        32'h00007FAD, 0));
    vt.push_back(v(0, 2'd1, 1, 32'h10,  32'h0,        32'h000080EF, 0));
    vt.push_back(v(0, 2'd1, 0, 32'h10,  32'h0,        32'hFFFF80EF, 0));

    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk($sformatf("reset%0d req_ready", s), 32'(req_ready), 32'd1);
      chk($sformatf("reset%0d resp_valid", s), 32'(resp_valid), 32'd0);
      chk($sformatf("reset%0d resp_rdata", s), resp_rdata, 32'd0);
      chk($sformatf("reset%0d resp_err", s), 32'(resp_err), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    sel = 0;
    foreach (vt[i]) do_req(vt[i], 0, $sformatf("vec%0d", i));

    sel = 1;
    do_req(v(1, 2'd2, 0, 32'h8, 32'h01020304, 32'h0,        0), 0, "ws0 sw");
    do_req(v(0, 2'd0, 1, 32'hB, 32'h0,        32'h00000001, 0), 0, "ws0 lbu");
    do_req(v(0, 2'd2, 0, 32'h8, 32'h0,        32'h01020304, 0), 5, "ws0 hold");

    sel = 2;
    do_req(v(1, 2'd2, 0, 32'h40, 32'h11223344, 32'h0,        0), 0, "ws3 sw");
    do_req(v(0, 2'd2, 0, 32'h40, 32'h0,        32'h11223344, 0), 5, "ws3 hold");

    wait_ready("midop");
    drive(1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A5A5A5);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("midop no resp %0d", i), 32'(resp_valid), 32'd0);
      @(posedge clk);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(v(0, 2'd2, 0, 32'h40, 32'h0, 32'h11223344, 0), 0, "midop old value");

    rst_in_resp(1'b1, 32'h44, 32'h0BADF00D, "resp rst sw");
    do_req(v(0, 2'd2, 0, 32'h44, 32'h0, 32'h0BADF00D, 0), 0, "committed persists");
    rst_in_resp(1'b0, 32'h44, 32'h0, "resp rst lw");

    chk("scoreboard empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
